// File: rtl/ascon_pkg.sv
// Shared constants, FSM encoding and helpers for the ASCON-128a finalization/verify stage.
// Round constants follow rc[i] = {~i[3:0], i[3:0]} for the twelve rounds of p12.
package ascon_pkg;

  localparam int ASCON_STATE_W   = 320;
  localparam int ASCON_RATE_128A = 128;
  localparam int NROUNDS         = 12;
  localparam int KEY_W           = 128;
  localparam int PT_W            = 256;
  localparam int RCW             = $clog2(NROUNDS + 1);

  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [7:0] ascon_rc(input logic [RCW-1:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (idx)
      4'd0:    rc = 8'hf0;
      4'd1:    rc = 8'he1;
      4'd2:    rc = 8'hd2;
      4'd3:    rc = 8'hc3;
      4'd4:    rc = 8'hb4;
      4'd5:    rc = 8'ha5;
      4'd6:    rc = 8'h96;
      4'd7:    rc = 8'h87;
      4'd8:    rc = 8'h78;
      4'd9:    rc = 8'h69;
      4'd10:   rc = 8'h5a;
      4'd11:   rc = 8'h4b;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant add, bitsliced 5-bit S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [ASCON_STATE_W-1:0] s_in,
  input  logic [7:0]               rc,
  output logic [ASCON_STATE_W-1:0] s_out
);

  logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [63:0] w_p0, w_p2, w_p4;
  logic [63:0] w_c0, w_c1, w_c2, w_c3, w_c4;
  logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  assign w_x0 = s_in[319:256];
  assign w_x1 = s_in[255:192];
  assign w_x2 = s_in[191:128] ^ {56'h0, rc};
  assign w_x3 = s_in[127:64];
  assign w_x4 = s_in[63:0];

  // S-box input mixing, chi-like core, then output mixing and x2 inversion
  assign w_p0 = w_x0 ^ w_x4;
  assign w_p4 = w_x4 ^ w_x3;
  assign w_p2 = w_x2 ^ w_x1;

  assign w_c0 = w_p0 ^ (~w_x1 & w_p2);
  assign w_c1 = w_x1 ^ (~w_p2 & w_x3);
  assign w_c2 = w_p2 ^ (~w_x3 & w_p4);
  assign w_c3 = w_x3 ^ (~w_p4 & w_p0);
  assign w_c4 = w_p4 ^ (~w_p0 & w_x1);

  assign w_s0 = w_c0 ^ w_c4;
  assign w_s1 = w_c1 ^ w_c0;
  assign w_s2 = ~w_c2;
  assign w_s3 = w_c3 ^ w_c2;
  assign w_s4 = w_c4;

  assign s_out[319:256] = w_s0 ^ ror64(w_s0, ROT_X0_A) ^ ror64(w_s0, ROT_X0_B);
  assign s_out[255:192] = w_s1 ^ ror64(w_s1, ROT_X1_A) ^ ror64(w_s1, ROT_X1_B);
  assign s_out[191:128] = w_s2 ^ ror64(w_s2, ROT_X2_A) ^ ror64(w_s2, ROT_X2_B);
  assign s_out[127:64]  = w_s3 ^ ror64(w_s3, ROT_X3_A) ^ ror64(w_s3, ROT_X3_B);
  assign s_out[63:0]    = w_s4 ^ ror64(w_s4, ROT_X4_A) ^ ror64(w_s4, ROT_X4_B);

endmodule

// File: rtl/ascon_final_verify.sv
// ASCON-128a decryption finalization: key-in, iterative p12, key-out, tag compare, plaintext gating.
// Handshake: start is a request sampled only in IDLE; done is a one-cycle pulse, results hold afterwards.
module ascon_final_verify
  import ascon_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ASCON_STATE_W-1:0] state_in,
  input  logic [PT_W-1:0]          pt_in,
  input  logic [KEY_W-1:0]         key,
  input  logic [KEY_W-1:0]         tag_in,
  output logic                     busy,
  output logic                     done,
  output logic [KEY_W-1:0]         tag_out,
  output logic                     tag_ok,
  output logic [PT_W-1:0]          pt_out,
  output logic [2:0]               dbg_state
);

  localparam logic [RCW-1:0] LAST_ROUND = RCW'(NROUNDS - 1);

  logic [2:0]               r_state;
  logic [RCW-1:0]           r_round_cnt;
  logic [KEY_W-1:0]         r_key_q;
  logic [KEY_W-1:0]         r_tag_q;
  logic [PT_W-1:0]          r_pt_q;
  logic [ASCON_STATE_W-1:0] r_s;
  logic                     r_done;
  logic [KEY_W-1:0]         r_tag_out;
  logic                     r_tag_ok;
  logic [PT_W-1:0]          r_pt_out;

  logic [ASCON_STATE_W-1:0] w_round_out;
  logic [7:0]               w_rc;
  logic [KEY_W-1:0]         w_tag;
  logic                     w_match;

  assign w_rc    = ascon_rc(r_round_cnt);
  assign w_tag   = r_s[127:0] ^ r_key_q;
  assign w_match = (w_tag == r_tag_q);

  ascon_round u_round (
    .s_in  (r_s),
    .rc    (w_rc),
    .s_out (w_round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_round_cnt <= '0;
      r_key_q     <= '0;
      r_tag_q     <= '0;
      r_pt_q      <= '0;
      r_s         <= '0;
      r_done      <= 1'b0;
      r_tag_out   <= '0;
      r_tag_ok    <= 1'b0;
      r_pt_out    <= '0;
    end else begin
      // done is registered off DONE so the pulse lands one edge after the state is entered
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key_q <= key;
            r_tag_q <= tag_in;
            r_pt_q  <= pt_in;
            r_s     <= state_in ^ {128'h0, key, 64'h0};
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_round_cnt <= '0;
          r_state     <= ST_ROUND;
        end
        ST_ROUND: begin
          r_s         <= w_round_out;
          r_round_cnt <= r_round_cnt + 1'b1;
          if (r_round_cnt == LAST_ROUND) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          r_tag_out <= w_tag;
          r_tag_ok  <= w_match;
          r_pt_out  <= w_match ? r_pt_q : '0;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state == ST_LOAD) || (r_state == ST_ROUND) || (r_state == ST_CHECK);
  assign done      = r_done;
  assign tag_out   = r_tag_out;
  assign tag_ok    = r_tag_ok;
  assign pt_out    = r_pt_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ascon_final_verify.sv
// Bench for ascon_final_verify: table-driven ASCON model, per-cycle compare, directed scenarios.
module tb_ascon_final_verify;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [319:0] state_in;
  logic [255:0] pt_in;
  logic [127:0] key;
  logic [127:0] tag_in;
  logic         busy;
  logic         done;
  logic [127:0] tag_out;
  logic         tag_ok;
  logic [255:0] pt_out;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  ascon_final_verify dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state_in  (state_in),
    .pt_in     (pt_in),
    .key       (key),
    .tag_in    (tag_in),
    .busy      (busy),
    .done      (done),
    .tag_out   (tag_out),
    .tag_ok    (tag_ok),
    .pt_out    (pt_out),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model (lookup-table S-box, word arrays) ----------------
  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  // first round of p12 applied to the all-zero state, worked out by hand
  localparam logic [319:0] ROUND1_ZERO = {64'h001E0F00000000F0, 64'h00000001E0000770,
                                          64'h3FFFFFFFFFFFFF74, 64'h3C780000000000F0, 64'h0};

  localparam logic [127:0] KAT_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_N  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KAT_PT = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int first, input int count);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  v;
    logic [319:0] o;
    for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
    for (int r = first; r < first + count; r++) begin
      x[2][7:0] = x[2][7:0] ^ RC[r];
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        v = SBOX[col];
        y[0][b] = v[4]; y[1][b] = v[3]; y[2][b] = v[2]; y[3][b] = v[1]; y[4][b] = v[0];
      end
      x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
      x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
      x[2] = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
      x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
      x[4] = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
    end
    o = '0;
    for (int w = 0; w < 5; w++) o[319-64*w -: 64] = x[w];
    return o;
  endfunction

  function automatic logic [127:0] final_tag(input logic [319:0] s, input logic [127:0] k);
    logic [319:0] t;
    t = s;
    t[191:64] = t[191:64] ^ k;
    t = perm(t, 0, 12);
    return t[127:0] ^ k;
  endfunction

  // full ASCON-128a front half: init, empty AD, two plaintext blocks, empty padded final block
  function automatic logic [319:0] upstream_state(input logic [127:0] k, input logic [127:0] n,
                                                  input logic [255:0] p);
    logic [319:0] s;
    s = {64'h80800c0800000000, k, n};
    s = perm(s, 0, 12);
    s[127:0] = s[127:0] ^ k;
    s[0] = ~s[0];
    s[319:192] = s[319:192] ^ p[255:128];
    s = perm(s, 4, 8);
    s[319:192] = s[319:192] ^ p[127:0];
    s = perm(s, 4, 8);
    s[319] = ~s[319];
    return s;
  endfunction

  function automatic logic [319:0] rand_bits();
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- cycle model: what the outputs must be after each edge ----------------
  int           m_age = -1;   // cycles since the accepting edge; -1 when no operation is pending
  logic [127:0] m_res_tag = '0;
  logic         m_res_ok  = 1'b0;
  logic [255:0] m_res_pt  = '0;
  logic [127:0] e_tag = '0;
  logic         e_ok  = 1'b0;
  logic [255:0] e_pt  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_age <= -1;
      e_tag <= '0;
      e_ok  <= 1'b0;
      e_pt  <= '0;
    end else if ((m_age == -1 || m_age == 15) && start) begin
      m_age     <= 0;
      m_res_tag <= final_tag(state_in, key);
      m_res_ok  <= (final_tag(state_in, key) == tag_in);
      m_res_pt  <= (final_tag(state_in, key) == tag_in) ? pt_in : 256'h0;
    end else if (m_age == 15) begin
      m_age <= -1;
    end else if (m_age >= 0) begin
      m_age <= m_age + 1;
      if (m_age == 13) begin
        e_tag <= m_res_tag;
        e_ok  <= m_res_ok;
        e_pt  <= m_res_pt;
      end
    end
  end

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (cmp_en) begin
      check("busy", busy, (m_age >= 0 && m_age <= 13));
      check("done", done, (m_age == 15));
      check("tag_out", tag_out, e_tag);
      check("tag_ok", tag_ok, e_ok);
      check("pt_out", pt_out, e_pt);
      if (tag_ok !== 1'b1) check("pt_gated", pt_out, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [319:0] s, input logic [255:0] p,
                          input logic [127:0] k, input logic [127:0] t);
    @(negedge clk);
    state_in = s; pt_in = p; key = k; tag_in = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
  endtask

  // ---------------- directed scenarios ----------------
  logic [319:0] kat_s;
  logic [127:0] kat_tag;
  logic [127:0] zero_tag;
  logic [319:0] rs;
  logic [127:0] rk;
  int lat;
  int d0;

  initial begin
    rst = 1'b1; start = 1'b0; state_in = '0; pt_in = '0; key = '0; tag_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tag_out", tag_out, 0);
    check("rst_tag_ok", tag_ok, 0);
    check("rst_pt_out", pt_out, 0);

    check("model_round1_zero", perm('0, 0, 1), ROUND1_ZERO);
    kat_s    = upstream_state(KAT_K, KAT_N, KAT_PT);
    kat_tag  = final_tag(kat_s, KAT_K);
    zero_tag = final_tag('0, '0);

    // 1: reference vector with its own tag
    drive_op(kat_s, KAT_PT, KAT_K, kat_tag);
    wait_done(lat);
    check("kat_latency", lat, 15);
    check("kat_tag_out", tag_out, kat_tag);
    check("kat_tag_ok", tag_ok, 1);
    check("kat_pt_out", pt_out, KAT_PT);

    // 2: same vector, received tag bit 0 flipped
    drive_op(kat_s, KAT_PT, KAT_K, kat_tag ^ 128'h1);
    wait_done(lat);
    check("bad_tag_out", tag_out, kat_tag);
    check("bad_tag_ok", tag_ok, 0);
    check("bad_pt_out", pt_out, 0);

    // 3: all-zero state and key, tag from the model's p12(0)
    drive_op('0, {8{32'ha5a5_5a5a}}, '0, zero_tag);
    repeat (2) @(negedge clk);
    check("zero_s_round1", dut.r_s, ROUND1_ZERO);
    wait_done(lat);
    check("zero_tag_out", tag_out, zero_tag);
    check("zero_tag_ok", tag_ok, 1);
    check("zero_pt_out", pt_out, {8{32'ha5a5_5a5a}});

    // 4: start held for 40 cycles; operations complete at 16-cycle spacing
    @(negedge clk);
    state_in = kat_s; pt_in = KAT_PT; key = KAT_K; tag_in = kat_tag; start = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    start = 1'b0;
    check("hold_done_pulses", done_cnt - d0, 2);
    wait_done(lat);

    // 5: reset at cycle 7 of an operation aborts it
    drive_op(kat_s, KAT_PT, KAT_K, kat_tag);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_tag_out", tag_out, 0);
    check("abort_tag_ok", tag_ok, 0);
    check("abort_pt_out", pt_out, 0);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    drive_op(kat_s, KAT_PT, KAT_K, kat_tag);
    wait_done(lat);
    check("after_abort_latency", lat, 15);
    check("after_abort_tag_ok", tag_ok, 1);

    // 5b: reset and start together, reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("rst_start_no_done", done_cnt - d0, 0);

    // 6: inputs churn every cycle after acceptance
    drive_op(kat_s, KAT_PT, KAT_K, kat_tag);
    for (int i = 0; i < 14; i++) begin
      state_in = rand_bits();
      pt_in    = {rand_bits(), rand_bits()};
      key      = rand_bits();
      tag_in   = rand_bits();
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(lat);
    check("churn_tag_out", tag_out, kat_tag);
    check("churn_tag_ok", tag_ok, 1);
    check("churn_pt_out", pt_out, KAT_PT);

    // random operands, alternating matching and non-matching tags
    for (int i = 0; i < 4; i++) begin
      rs = rand_bits();
      rk = rand_bits();
      drive_op(rs, {rand_bits(), rand_bits()}, rk, (i % 2 == 0) ? final_tag(rs, rk) : rand_bits());
      wait_done(lat);
      check("rand_latency", lat, 15);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
